// File: rtl/gpio_proto_pkg.sv
// Shared GPIO message protocol definitions: FSM states, default sizing, pin map.
// No logic; imported by the transmitter and its divider.
package gpio_proto_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DEF_DATA_W  = 4;
  localparam int DEF_DEPTH   = 32;
  localparam int DEF_CLK_DIV = 25;

  // Bit positions of the message lines on the GPIO header
  localparam int GPIO_DATA_LSB = 0;
  localparam int GPIO_DATA_MSB = 3;
  localparam int GPIO_SCLK_BIT = 4;
  localparam int GPIO_DONE_BIT = 5;
  localparam int GPIO_PAR_BIT  = 6;

endpackage

// File: rtl/gpio_tick_gen.sv
// Free-running divider: one-cycle tick every CLK_DIV enabled cycles, at count CLK_DIV-1.
// Tick is combinational from the count register; clr wins over en.
module gpio_tick_gen
  import gpio_proto_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] TOP = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == TOP);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gpio_msg_tx.sv
// Sends msg_len buffered words over GPIO with a shared sclk; (2N+1)*CLK_DIV cycles per message.
// Writes and starts are ignored while busy. Optional gpio_par output under GPIO_MSG_TX_PARITY_EN.
module gpio_msg_tx
  import gpio_proto_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic                       CLOCK_50,
  input  logic                       RESET_N,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [$clog2(DEPTH):0]     msg_len,
  input  logic                       start,
  output logic                       busy,
  output logic [DATA_W-1:0]          gpio_data,
  output logic                       gpio_sclk,
  output logic                       gpio_done
`ifdef GPIO_MSG_TX_PARITY_EN
  ,
  output logic                       gpio_par
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  state_t             state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [AW:0]        len_q, len_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               busy_q, busy_d;
  logic               sclk_q, sclk_d;
  logic               done_q, done_d;
  logic               par_q, par_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic tick, div_clr, div_en, len_ok, last_word, load;

  gpio_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .clr      (div_clr),
    .en       (div_en),
    .tick     (tick)
  );

  assign div_en    = (state_q != ST_IDLE);
  assign len_ok    = (msg_len != '0) && (msg_len <= DEPTH_L);
  assign last_word = ({1'b0, idx_q} == (len_q - 1'b1));

  // Buffer is intentionally not reset
  always_ff @(posedge CLOCK_50) begin
    if (wr_en && !busy_q) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    div_clr = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && len_ok) begin
          state_d = ST_SETUP;
          len_d   = msg_len;
          idx_d   = '0;
          div_clr = 1'b1;
          load    = 1'b1;
        end
      end
      ST_SETUP: if (tick) state_d = ST_HIGH;
      ST_HIGH: begin
        if (tick) begin
          if (last_word) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_LOW;
            load    = 1'b1;
          end
        end
      end
      ST_LOW:  if (tick) state_d = ST_HIGH;
      ST_DONE: if (tick) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state, so data only moves on SETUP/LOW entry
    data_d = data_q;
    if (state_d == ST_IDLE) begin
      data_d = '0;
    end else if (load) begin
      data_d = mem_q[idx_d];
    end
    busy_d = (state_d != ST_IDLE);
    sclk_d = (state_d == ST_HIGH);
    done_d = (state_d == ST_DONE);
    par_d  = ^data_d;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      done_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      done_q  <= done_d;
      par_q   <= par_d;
    end
  end

  assign busy      = busy_q;
  assign gpio_data = data_q;
  assign gpio_sclk = sclk_q;
  assign gpio_done = done_q;

`ifdef GPIO_MSG_TX_PARITY_EN
  assign gpio_par = par_q;
`else
  logic unused_par;
  assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_gpio_msg_tx.sv
// Directed + randomized bench for gpio_msg_tx with a word-level message model.
module tb_gpio_msg_tx;

  localparam int DW  = 4;
  localparam int DEP = 32;
  localparam int DIV = 2;

  logic          CLOCK_50 = 1'b0;
  logic          RESET_N  = 1'b0;
  logic          wr_en    = 1'b0;
  logic [4:0]    wr_addr  = '0;
  logic [DW-1:0] wr_data  = '0;
  logic [5:0]    msg_len  = '0;
  logic          start    = 1'b0;
  logic          busy;
  logic [DW-1:0] gpio_data;
  logic          gpio_sclk;
  logic          gpio_done;
`ifdef GPIO_MSG_TX_PARITY_EN
  logic          gpio_par;
`endif

  gpio_msg_tx #(.DATA_W(DW), .DEPTH(DEP), .CLK_DIV(DIV)) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .msg_len   (msg_len),
    .start     (start),
    .busy      (busy),
    .gpio_data (gpio_data),
    .gpio_sclk (gpio_sclk),
    .gpio_done (gpio_done)
`ifdef GPIO_MSG_TX_PARITY_EN
    ,
    .gpio_par  (gpio_par)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mdl_buf [DEP];

  // Receiver-side monitor, sampled on the falling edge
  logic          mon_clr = 1'b1;
  int            busy_cyc, done_cyc, viol;
  logic [DW-1:0] cap_q [$];
  logic          par_q [$];
  logic          sclk_prev = 1'b0;
  logic [DW-1:0] data_prev = '0;

  always @(negedge CLOCK_50) begin
    if (mon_clr) begin
      busy_cyc = 0;
      done_cyc = 0;
      viol     = 0;
      cap_q.delete();
      par_q.delete();
    end else begin
      if (busy === 1'b1) busy_cyc++;
      if (gpio_done === 1'b1) done_cyc++;
      if (gpio_sclk === 1'b1 && sclk_prev === 1'b0) begin
        cap_q.push_back(gpio_data);
`ifdef GPIO_MSG_TX_PARITY_EN
        par_q.push_back(gpio_par);
`else
        par_q.push_back(^gpio_data);
`endif
      end
      if (gpio_sclk === 1'b1 && gpio_data !== data_prev) viol++;
    end
    sclk_prev = gpio_sclk;
    data_prev = gpio_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    @(negedge CLOCK_50);
    #1 mon_clr = 1'b0;
  endtask

  task automatic write_word(input int a, input logic [DW-1:0] d, input bit upd);
    @(negedge CLOCK_50);
    wr_en = 1'b1; wr_addr = 5'(a); wr_data = d;
    if (upd) mdl_buf[a] = d;
    @(negedge CLOCK_50);
    wr_en = 1'b0;
  endtask

  task automatic kick(input int len);
    @(negedge CLOCK_50);
    start = 1'b1; msg_len = 6'(len);
    @(negedge CLOCK_50);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("idle_timeout", (n < limit), 1);
    repeat (2) @(negedge CLOCK_50);
  endtask

  // Expected message behaviour derived from word count alone
  task automatic check_send(input string tag, input int n);
    int m;
    chk({tag, "_rises"}, cap_q.size(), n);
    chk({tag, "_busy"}, busy_cyc, (2 * n + 1) * DIV);
    chk({tag, "_done"}, done_cyc, DIV);
    chk({tag, "_hold"}, viol, 0);
    m = (cap_q.size() < n) ? cap_q.size() : n;
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s_w%0d", tag, i), cap_q[i], mdl_buf[i]);
      chk($sformatf("%s_p%0d", tag, i), par_q[i], ^mdl_buf[i]);
    end
  endtask

  task automatic send(input string tag, input int n);
    clr_mon();
    kick(n);
    wait_idle(10 * (2 * n + 1) * DIV + 20);
    check_send(tag, n);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset and idle
    repeat (3) @(negedge CLOCK_50);
    chk("rst_busy", busy, 0);
    chk("rst_data", gpio_data, 0);
    RESET_N = 1'b1;
    clr_mon();
    repeat (100) @(negedge CLOCK_50);
    chk("idle_sclk", cap_q.size(), 0);
    chk("idle_busy", busy_cyc, 0);
    chk("idle_outs", {busy, gpio_sclk, gpio_done, gpio_data}, 0);

    // Counting pattern, 16 words
    for (int i = 0; i < 16; i++) write_word(i, DW'(i), 1'b1);
    send("cnt16", 16);

    // Out-of-range lengths are ignored
    clr_mon();
    kick(0);
    chk("len0_busy", busy, 0);
    kick(33);
    chk("len33_busy", busy, 0);
    repeat (20) @(negedge CLOCK_50);
    chk("badlen_busy", busy_cyc, 0);
    chk("badlen_sclk", cap_q.size(), 0);

    // Writes and starts while busy are ignored
    for (int i = 0; i < 4; i++) write_word(i, DW'($urandom_range(0, 15)), 1'b1);
    clr_mon();
    kick(4);
    repeat (3) @(negedge CLOCK_50);
    write_word(0, ~mdl_buf[0], 1'b0);
    kick(8);
    wait_idle(200);
    check_send("busywr", 4);
    send("busywr_w0", 1);

    // Reset during HIGH
    for (int i = 0; i < 4; i++) write_word(i, DW'($urandom_range(1, 15)), 1'b1);
    kick(4);
    n = 0;
    while (gpio_sclk !== 1'b1 && n < 50) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("high_seen", gpio_sclk, 1);
    @(negedge CLOCK_50);
    #2 RESET_N = 1'b0;
    #1;
    chk("arst_sclk", gpio_sclk, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data", gpio_data, 0);
    chk("arst_done", gpio_done, 0);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    send("after_rst", 3);

    // Full-depth message, then random lengths and contents
    for (int i = 0; i < DEP; i++) write_word(i, DW'($urandom_range(0, 15)), 1'b1);
    send("full32", DEP);
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, DEP);
      for (int i = 0; i < n; i++) write_word(i, DW'($urandom_range(0, 15)), 1'b1);
      send($sformatf("rnd%0d", k), n);
    end

`ifdef GPIO_MSG_TX_PARITY_EN
    write_word(0, 4'h3, 1'b1);
    write_word(1, 4'h7, 1'b1);
    send("par", 2);
    chk("par_w3", (par_q.size() > 0) ? par_q[0] : 1'bx, 0);
    chk("par_w7", (par_q.size() > 1) ? par_q[1] : 1'bx, 1);
    chk("par_idle", gpio_par, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_msg_tx.md
GPIO_MSG_TX -- requirements
Module: gpio_msg_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, meaning width of one message word on the GPIO data lines.
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning the number of message buffer words (power of two, 2..256).
REQ-003 The block SHALL have parameter CLK_DIV, default 25, meaning CLOCK_50 cycles per shared-clock half-period (>=2).
REQ-004 Port list, in order: name, direction, width, meaning.
- CLOCK_50  in  1  sole clock.
- RESET_N  in  1  asynchronous, active-low reset.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  clog2(DEPTH)  buffer write address.
- wr_data  in  DATA_W  buffer write data.
- msg_len  in  clog2(DEPTH)+1  number of words to send, sampled on accepted start.
- start  in  1  send request.
- busy  out  1  transfer in progress.
- gpio_data  out  DATA_W  message data lines.
- gpio_sclk  out  1  shared clock to the receiver.
- gpio_done  out  1  message-done flag.

Function
REQ-005 A write SHALL update buffer[wr_addr] on the CLOCK_50 edge with wr_en=1 and busy=0; writes while busy=1 SHALL be ignored.
REQ-006 The FSM SHALL have states IDLE, SETUP, HIGH, LOW and DONE.
REQ-007 IDLE outputs: busy=0, gpio_sclk=0, gpio_done=0, gpio_data=0.
REQ-008 start=1 in IDLE with msg_len in 1..DEPTH SHALL latch msg_len, clear word index idx to 0, clear the divider and enter SETUP next cycle; busy=1 from that cycle.
REQ-009 start with msg_len=0 or msg_len>DEPTH SHALL be ignored (stay IDLE); start while busy SHALL be ignored.
REQ-010 The divider SHALL assert a one-cycle tick every CLK_DIV cycles while not IDLE, counting 0..CLK_DIV-1 and ticking at CLK_DIV-1.
REQ-011 SETUP: gpio_data=buffer[0], gpio_sclk=0; on tick go to HIGH.
REQ-012 HIGH: gpio_sclk=1, gpio_data held; on tick go to DONE if idx=len-1, else increment idx and go to LOW.
REQ-013 LOW: gpio_sclk=0, gpio_data=buffer[idx], updated in the first LOW cycle; on tick go to HIGH.
REQ-014 gpio_data SHALL change only while gpio_sclk=0, giving the receiver CLK_DIV cycles of setup and hold around each rising edge.
REQ-015 DONE: gpio_done=1, gpio_sclk=0, gpio_data=last word; on tick go to IDLE, where busy and gpio_done drop.
REQ-016 A message of N words SHALL take exactly (2N+1)*CLK_DIV cycles from the SETUP entry to IDLE re-entry.
REQ-017 idx SHALL never wrap; msg_len=DEPTH SHALL send buffer[0..DEPTH-1] once.
REQ-018 All outputs SHALL be registered.

Reset
REQ-019 RESET_N=0 SHALL asynchronously force IDLE with idx=0, divider=0, busy=0, gpio_sclk=0, gpio_done=0 and gpio_data=0, including in the middle of a transfer.
REQ-020 Buffer contents SHALL NOT be reset.

Configuration
REQ-021 With GPIO_MSG_TX_PARITY_EN defined, the block SHALL add output gpio_par (1 bit), equal to the even parity (XOR) of gpio_data, registered and updated in the same cycle as gpio_data, and 0 in IDLE and reset.
REQ-022 Without GPIO_MSG_TX_PARITY_EN, gpio_par SHALL NOT exist and behaviour SHALL otherwise be identical.

Structure
REQ-023 The shared package gpio_proto_pkg SHALL hold the FSM state enum, the default DATA_W/DEPTH/CLK_DIV constants, and the GPIO bit-position constants: data [3:0], sclk 4, done 5, par 6.
REQ-024 The divider SHALL be the sub-module gpio_tick_gen, with parameter CLK_DIV and ports CLOCK_50, RESET_N, clr, en and tick.

Verification
REQ-025 Reset then idle, with CLK_DIV=2: all outputs 0, busy=0, and no gpio_sclk edges for 100 cycles.
REQ-026 Write 0,1,..,F then start with msg_len=16 and CLK_DIV=2: 16 gpio_sclk rising edges; data sampled at those edges is 0..F; gpio_done is high for 2 cycles; busy lasts 66 cycles.
REQ-027 start with msg_len=0 and then 33, with DEPTH=32: busy stays 0 and there is no sclk activity.
REQ-028 During a 4-word send, pulse wr_en to address 0 and pulse start: buffer[0] is unchanged and only 4 rising edges occur.
REQ-029 Assert RESET_N=0 in the middle of HIGH: gpio_sclk=0, busy=0 and gpio_data=0 immediately; a new start after release sends from word 0.
REQ-030 With PARITY_EN and words 3 and 7: gpio_par is 0 for word 3, 1 for word 7, and 0 in IDLE.
